// File: rtl/tc_lfsr8_checker_if.sv
// Word stream from the 8-bit LFSR generator into its sequence checker.
interface tc_lfsr8_checker_if;
  logic [7:0] DIN;
  logic       DIN_VALID;

  modport master (output DIN, output DIN_VALID);
  modport slave  (input  DIN, input  DIN_VALID);
endinterface

// File: rtl/tc_lfsr8_checker.sv
// Word-level sequence checker for the 8-bit LFSR: seeds a local predictor,
// locks after LOCK_CNT good words, then flywheels and counts mismatches.
module tc_lfsr8_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CW       = 8
) (
  input  logic                    phi,
  input  logic                    RST_N,
  tc_lfsr8_checker_if.slave       bus,
  input  logic                    CLR,
  output logic                    LOCKED,
  output logic                    ERR,
  output logic [CW-1:0]           ERR_CNT,
  output logic [1:0]              STATE
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t        state;
  logic [7:0]    pred;
  logic [3:0]    run;
  logic [3:0]    bad;
  logic          locked_r;
  logic          err_r;
  logic [CW-1:0] err_cnt_r;

  logic [3:0]    run_inc;
  logic [3:0]    bad_inc;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[0], x[7], x[6] ^ x[0], x[5] ^ x[0], x[4] ^ x[0], x[3], x[2], x[1]};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign run_inc = run + 4'd1;
  assign bad_inc = bad + 4'd1;

  always_ff @(posedge phi or negedge RST_N) begin
    if (!RST_N) begin
      state     <= HUNT;
      locked_r  <= 1'b0;
      err_r     <= 1'b0;
      err_cnt_r <= '0;
      pred      <= 8'h00;
      run       <= 4'd0;
      bad       <= 4'd0;
    end else begin
      err_r <= 1'b0;
      if (CLR) begin
        state     <= HUNT;
        locked_r  <= 1'b0;
        err_cnt_r <= '0;
        run       <= 4'd0;
        bad       <= 4'd0;
      end else if (bus.DIN_VALID) begin
        case (state)
          HUNT: begin
            // The all-zero lock-up word can never seed the predictor.
            if (bus.DIN != 8'h00) begin
              pred  <= lfsr_next(bus.DIN);
              run   <= 4'd0;
              state <= SYNC;
            end
          end
          SYNC: begin
            if (bus.DIN == 8'h00) begin
              state <= HUNT;
            end else if (bus.DIN == pred) begin
              pred <= lfsr_next(bus.DIN);
              run  <= run_inc;
              if (run_inc == LOCK_N) begin
                state    <= LOCK;
                locked_r <= 1'b1;
                bad      <= 4'd0;
              end
            end else begin
              pred <= lfsr_next(bus.DIN);
              run  <= 4'd0;
            end
          end
          LOCK: begin
            // Flywheel: the predictor free-runs and ignores DIN unless lock is lost.
            pred <= lfsr_next(pred);
            if (bus.DIN == pred) begin
              bad <= 4'd0;
            end else begin
              err_r     <= 1'b1;
              err_cnt_r <= sat_inc(err_cnt_r);
              bad       <= bad_inc;
              if (bad_inc == LOSS_N) begin
                state    <= SYNC;
                locked_r <= 1'b0;
                pred     <= lfsr_next(bus.DIN);
                run      <= 4'd0;
              end
            end
          end
          default: begin
            state    <= HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign STATE   = state;
  assign LOCKED  = locked_r;
  assign ERR     = err_r;
  assign ERR_CNT = err_cnt_r;

endmodule

// File: tb/tb_tc_lfsr8_checker.sv
// Directed bench for tc_lfsr8_checker: lock, flywheel errors, loss of lock,
// zero words, gaps, CLR, asynchronous reset and counter saturation.
module tb_tc_lfsr8_checker;

  logic       phi;
  logic       RST_N;
  logic       CLR;

  logic       locked, err;
  logic [7:0] err_cnt;
  logic [1:0] state;

  logic       locked2, err2;
  logic [1:0] err_cnt2;
  logic [1:0] state2;

  int n_run;
  int n_fail;

  tc_lfsr8_checker_if bus ();

  tc_lfsr8_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CW(8)) dut (
    .phi     (phi),
    .RST_N   (RST_N),
    .bus     (bus.slave),
    .CLR     (CLR),
    .LOCKED  (locked),
    .ERR     (err),
    .ERR_CNT (err_cnt),
    .STATE   (state)
  );

  tc_lfsr8_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .CW(2)) dut_sat (
    .phi     (phi),
    .RST_N   (RST_N),
    .bus     (bus.slave),
    .CLR     (CLR),
    .LOCKED  (locked2),
    .ERR     (err2),
    .ERR_CNT (err_cnt2),
    .STATE   (state2)
  );

  initial phi = 1'b0;
  always #5 phi = ~phi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    @(negedge phi);
    bus.DIN       = d;
    bus.DIN_VALID = v;
    CLR           = c;
    @(posedge phi);
    #1;
  endtask

  task automatic word(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    RST_N  = 1'b0;
    CLR    = 1'b0;
    bus.DIN       = 8'h00;
    bus.DIN_VALID = 1'b0;
    repeat (3) @(posedge phi);
    @(negedge phi);
    RST_N = 1'b1;
    #1;
    chk("rst_state",   state,   0);
    chk("rst_locked",  locked,  0);
    chk("rst_err",     err,     0);
    chk("rst_errcnt",  err_cnt, 0);
    chk("rst_state2",  state2,  0);

    // Zero word never seeds from HUNT
    word(8'h00); chk("hunt_zero", state, 0);

    // Lock acquisition
    word(8'h01); chk("seed_state", state, 1); chk("seed_locked", locked, 0);
    word(8'hB8); word(8'h5C); word(8'h2E);
    chk("sync_run3_state", state, 1);
    chk("sync_run3_locked", locked, 0);
    word(8'h17);
    chk("lock_state", state, 2); chk("lock_locked", locked, 1); chk("lock_errcnt", err_cnt, 0);

    // Flywheel single error, then zero word and a second error to prove bad was cleared
    word(8'hB3); chk("fly_ok_err", err, 0);
    word(8'hFF); chk("fly_bad_err", err, 1); chk("fly_bad_cnt", err_cnt, 1); chk("fly_bad_locked", locked, 1);
    word(8'hC8); chk("fly_recover_err", err, 0); chk("fly_recover_locked", locked, 1);
    word(8'h00); chk("lock_zero_err", err, 1); chk("lock_zero_cnt", err_cnt, 2);
    word(8'h55); chk("bad_cleared_state", state, 2); chk("bad_cleared_cnt", err_cnt, 3);
    word(8'h19); chk("fly_ok2_err", err, 0);

    // Loss of lock: three consecutive wrong words, reseed from the third
    word(8'hAA); word(8'h55);
    chk("loss2_state", state, 2);
    word(8'h01);
    chk("loss_state", state, 1); chk("loss_locked", locked, 0);
    chk("loss_err", err, 1); chk("loss_cnt", err_cnt, 6);
    word(8'hB8); word(8'h5C); word(8'h2E);
    chk("relock3_state", state, 1);
    word(8'h17);
    chk("relock_state", state, 2); chk("relock_locked", locked, 1); chk("relock_cnt_held", err_cnt, 6);

    // Gaps with garbage DIN
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'hFF, 1'b0);
    chk("gap_state", state, 2); chk("gap_err", err, 0); chk("gap_cnt", err_cnt, 6);
    word(8'hB3); chk("gap_after_err", err, 0); chk("gap_after_state", state, 2);

    // CLR wins over a valid word while locked
    cyc(1'b1, 8'h55, 1'b1);
    chk("clr_state", state, 0); chk("clr_cnt", err_cnt, 0); chk("clr_locked", locked, 0); chk("clr_err", err, 0);

    // SYNC: zero word returns to HUNT
    word(8'h01); chk("sync_again", state, 1);
    word(8'h00); chk("sync_zero", state, 0);

    // SYNC: a wrong nonzero word reseeds and restarts the run
    word(8'h01); word(8'hB8); word(8'h5C);
    word(8'h17); chk("reseed_state", state, 1); chk("reseed_err", err, 0);
    word(8'hB3); word(8'hE1); word(8'hC8);
    chk("reseed_run3_state", state, 1); chk("sync_no_count", err_cnt, 0);
    word(8'h64); chk("reseed_lock", state, 2); chk("reseed_locked", locked, 1);

    // Asynchronous reset in the middle of a cycle, while ERR is high
    word(8'hFF); chk("pre_rst_err", err, 1); chk("pre_rst_cnt", err_cnt, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_state", state, 0); chk("arst_locked", locked, 0);
    chk("arst_err", err, 0); chk("arst_cnt", err_cnt, 0);
    @(negedge phi);
    bus.DIN_VALID = 1'b0;
    RST_N = 1'b1;

    // Saturation on the CW=2, LOSS_CNT=15 instance
    word(8'h01); word(8'hB8); word(8'h5C); word(8'h2E); word(8'h17);
    chk("sat_lock", state2, 2);
    word(8'hFF); chk("sat_cnt1", err_cnt2, 1);
    word(8'hFF); chk("sat_cnt2", err_cnt2, 2);
    word(8'hFF); chk("sat_cnt3", err_cnt2, 3);
    word(8'hFF); chk("sat_cnt4", err_cnt2, 3);
    word(8'hFF); chk("sat_cnt5", err_cnt2, 3);
    chk("sat_still_locked", locked2, 1);
    cyc(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
